// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: datapath width, the NOP bubble word,
// the fetch FSM state encoding and a word-alignment helper.
package rv32_pkg;

    localparam int XLEN = 32;

    // Canonical RV32I NOP (addi x0, x0, 0) used as the bubble on inst.
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    // Clear the byte-offset bits so an address points at a whole word.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode handshakes.
// master = fetch stage side, slave = memory/decode/branch environment side.
interface fetch_stage_if;
    import rv32_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready;

    modport master (
        output imem_req_valid, imem_addr, inst, inst_pc, inst_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst, inst_pc, inst_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: a redirect target (word aligned) beats sequential
// advance; otherwise the PC holds.
module fetch_pc_gen
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_advance,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_next_pc
);

    // Priority select of the next fetch address; +4 wraps naturally mod 2^32.
    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect) begin
            o_next_pc = align_word(i_redirect_pc);
        end else if (i_advance) begin
            o_next_pc = i_pc + 32'd4;
        end else begin
            o_next_pc = i_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a single output
// register toward decode, and redirect handling that drops in-flight
// responses through a kill flag.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            r_kill;
    logic            w_kill_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_inst_valid;
    logic            w_req_valid;
    logic            w_load;

    fetch_pc_gen u_pc_gen (
        .i_pc          (r_pc),
        .i_advance     (w_load),
        .i_redirect    (bus.redirect_valid),
        .i_redirect_pc (bus.redirect_pc),
        .o_next_pc     (w_next_pc)
    );

    // Next state, kill flag, request qualification and response-load decision.
    always_comb begin
        w_state_next = r_state;
        w_kill_next  = r_kill;
        w_req_valid  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                // Only request when the output register will have room for the reply.
                w_req_valid = !r_inst_valid || bus.inst_ready;
                if (w_req_valid && bus.imem_req_ready) begin
                    w_state_next = S_WAIT;
                    w_kill_next  = bus.redirect_valid;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_state_next = S_REQ;
                    w_kill_next  = 1'b0;
                    w_load       = !r_kill && !bus.redirect_valid;
                end else if (bus.redirect_valid) begin
                    w_kill_next  = 1'b1;
                end else begin
                    w_kill_next  = r_kill;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_kill_next  = 1'b0;
            end
        endcase
    end

    // FSM state, kill flag and fetch PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_kill  <= w_kill_next;
            r_pc    <= w_next_pc;
        end
    end

    // Output register toward decode: redirect flush, response load, consume, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst       <= NOP;
            r_inst_pc    <= 32'h0000_0000;
            r_inst_valid <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
        end else if (w_load) begin
            r_inst       <= bus.imem_rsp_data;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
        end else if (r_inst_valid && bus.inst_ready) begin
            r_inst       <= NOP;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst       <= r_inst;
            r_inst_pc    <= r_inst_pc;
            r_inst_valid <= r_inst_valid;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = align_word(r_pc);
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign bus.inst_valid     = r_inst_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage with a transaction-level
// reference model: every accepted request remembers its address; a response
// to a request not made stale by a redirect is presented with that address.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W   = 32'h0000_0013;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_idle, m_outst, m_stale, m_full;
    logic [31:0] m_data, m_opc, m_npc, m_raddr;
    // Memory model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    // Stimulus knobs
    int lat_min = 1, lat_max = 1, rdy_pct = 100, iry_pct = 100, redir_pct = 0;
    int force_mode = 0;
    logic [31:0] force_tgt = 32'h0;
    // Observation logs
    logic [31:0] req_log[$];
    logic [31:0] pres_log[$];
    int valid_cycles = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_outst = 1'b0; m_stale = 1'b0; m_full = 1'b0;
        m_data = NOP_W; m_opc = 32'h0; m_npc = RST_PC; m_raddr = 32'h0;
        mem_busy = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
    endtask

    // Compare DUT outputs with the model, then advance memory and model by one edge.
    task automatic evaluate();
        logic e_req, hs, rsp, rd, dut_hs;
        e_req = !m_idle && !m_outst && (!m_full || bus.inst_ready);
        check1("req_valid", bus.imem_req_valid, e_req);
        if (e_req) check32("imem_addr", bus.imem_addr, m_npc);
        check32("inst", bus.inst, m_full ? m_data : NOP_W);
        check32("inst_pc", bus.inst_pc, m_opc);
        check1("inst_valid", bus.inst_valid, m_full);

        dut_hs = bus.imem_req_valid && bus.imem_req_ready;
        if (dut_hs) req_log.push_back(bus.imem_addr);
        if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) pres_log.push_back(bus.inst_pc);
        if (bus.inst_valid) valid_cycles++;

        if (bus.imem_rsp_valid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (dut_hs) begin
            check1("one_outstanding", mem_busy, 1'b0);
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
        end

        hs  = e_req && bus.imem_req_ready;
        rsp = bus.imem_rsp_valid;
        rd  = bus.redirect_valid;
        if (rd) begin
            if (rsp) begin m_outst = 1'b0; m_stale = 1'b0; end
            else if (m_outst) m_stale = 1'b1;
            if (hs) begin m_outst = 1'b1; m_stale = 1'b1; m_raddr = m_npc; end
            m_full = 1'b0;
            m_data = NOP_W;
            m_npc  = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (rsp && m_outst) begin
                if (!m_stale) begin
                    m_full = 1'b1; m_data = mem_fn(m_raddr);
                    m_opc = m_raddr; m_npc = m_raddr + 32'd4;
                end
                m_outst = 1'b0; m_stale = 1'b0;
            end else if (m_full && bus.inst_ready) begin
                m_full = 1'b0; m_data = NOP_W;
            end
            if (hs) begin m_outst = 1'b1; m_stale = 1'b0; m_raddr = m_npc; end
        end
        m_idle = 1'b0;
    endtask

    // Drive this cycle's inputs from knobs, memory state and any pending forced redirect.
    task automatic drive();
        logic rsp, rd, ird, e_next;
        logic [31:0] tgt;
        bus.imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        ird = ($urandom_range(99, 0) < iry_pct);
        bus.inst_ready = ird;
        rsp = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_fn(mem_addr) : $urandom();
        rd  = ($urandom_range(99, 0) < redir_pct);
        tgt = $urandom();
        e_next = !m_idle && !m_outst && (!m_full || ird);
        case (force_mode)
            1: if (m_outst && !rsp) begin rd = 1'b1; tgt = force_tgt; force_mode = 0; end else rd = 1'b0;
            2: if (rsp) begin rd = 1'b1; tgt = force_tgt; force_mode = 0; end else rd = 1'b0;
            3: if (e_next && bus.imem_req_ready) begin rd = 1'b1; tgt = force_tgt; force_mode = 0; end else rd = 1'b0;
            default: ;
        endcase
        bus.redirect_valid = rd;
        bus.redirect_pc    = tgt;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        evaluate();
    endtask

    task automatic zero_inputs();
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b0;
    endtask

    // Assert reset at the current time, check the asynchronous effect, release after two edges.
    task automatic do_reset();
        rst = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        check32("rst_inst", bus.inst, NOP_W);
        check1("rst_inst_valid", bus.inst_valid, 1'b0);
        check1("rst_req_valid", bus.imem_req_valid, 1'b0);
        check32("rst_inst_pc", bus.inst_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        evaluate();
    endtask

    task automatic run_force(input int mode, input logic [31:0] tgt);
        force_tgt  = tgt;
        force_mode = mode;
        for (int k = 0; k < 60 && force_mode != 0; k++) cycle();
        check1("force_timeout", force_mode == 0, 1'b1);
        force_mode = 0;
    endtask

    task automatic wait_pres(input int p);
        for (int k = 0; k < 60 && pres_log.size() <= p; k++) cycle();
        check1("pres_timeout", pres_log.size() > p, 1'b1);
    endtask

    task automatic wait_req(input int n);
        for (int k = 0; k < 60 && req_log.size() <= n; k++) cycle();
        check1("req_timeout", req_log.size() > n, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p, v0;
        logic [31:0] s_inst, s_pc;
        #2;
        do_reset();

        // Streaming fetch: addresses 0,4,8 and a valid every other cycle.
        n = req_log.size(); p = pres_log.size();
        repeat (6) cycle();
        v0 = valid_cycles;
        repeat (10) cycle();
        check32("valid_every_other", valid_cycles - v0, 32'd5);
        check32("first_req_addr", req_log.size() > n ? req_log[n] : 32'hDEAD_BEEF, 32'h0);
        check32("pres0", pres_log.size() > p ? pres_log[p] : 32'hDEAD_BEEF, 32'h0);
        check32("pres1", pres_log.size() > p + 1 ? pres_log[p + 1] : 32'hDEAD_BEEF, 32'h4);
        check32("pres2", pres_log.size() > p + 2 ? pres_log[p + 2] : 32'hDEAD_BEEF, 32'h8);

        // Decode stall: output holds and no request goes out.
        iry_pct = 0;
        for (int k = 0; k < 20 && !bus.inst_valid; k++) cycle();
        check1("stall_valid_timeout", bus.inst_valid, 1'b1);
        s_inst = bus.inst; s_pc = bus.inst_pc; n = req_log.size();
        repeat (5) cycle();
        check32("stall_inst_hold", bus.inst, s_inst);
        check32("stall_pc_hold", bus.inst_pc, s_pc);
        check32("stall_no_req", req_log.size(), n);
        iry_pct = 100;
        cycle();
        check32("stall_release_req", req_log.size(), n + 1);

        // Redirect while waiting on a slow response.
        lat_min = 3; lat_max = 3;
        run_force(1, 32'h0000_0102);
        n = req_log.size(); p = pres_log.size();
        wait_req(n);
        check32("redir_wait_addr", req_log.size() > n ? req_log[n] : 32'hDEAD_BEEF, 32'h0000_0100);
        wait_pres(p);
        check32("redir_wait_pres", pres_log.size() > p ? pres_log[p] : 32'hDEAD_BEEF, 32'h0000_0100);

        // Redirect coinciding with a response, then with a request handshake.
        lat_min = 1; lat_max = 1;
        run_force(2, 32'h0000_2000);
        p = pres_log.size();
        wait_pres(p);
        check32("redir_rsp_pres", pres_log.size() > p ? pres_log[p] : 32'hDEAD_BEEF, 32'h0000_2000);
        run_force(3, 32'h0000_3001);
        p = pres_log.size();
        wait_pres(p);
        check32("redir_hs_pres", pres_log.size() > p ? pres_log[p] : 32'hDEAD_BEEF, 32'h0000_3000);

        // PC wrap at the top of the address space.
        lat_min = 2; lat_max = 2;
        run_force(1, 32'hFFFF_FFFE);
        n = req_log.size();
        wait_req(n + 1);
        check32("wrap_addr0", req_log.size() > n ? req_log[n] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check32("wrap_addr1", req_log.size() > n + 1 ? req_log[n + 1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Randomized traffic.
        lat_min = 1; lat_max = 4; rdy_pct = 60; iry_pct = 60; redir_pct = 4;
        repeat (3000) cycle();

        // Reset while a request is outstanding.
        lat_min = 3; lat_max = 3; rdy_pct = 100; iry_pct = 100; redir_pct = 0;
        for (int k = 0; k < 30 && !m_outst; k++) cycle();
        check1("outst_timeout", m_outst, 1'b1);
        @(posedge clk);
        #3;
        do_reset();
        lat_min = 1; lat_max = 1;
        n = req_log.size();
        repeat (10) cycle();
        check32("restart_addr", req_log.size() > n ? req_log[n] : 32'hDEAD_BEEF, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
